// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for an 8:1 mux select; one idle cycle separates consecutive owners.
// The early-release input is named "rel" because "release" is a reserved word.
// The optional hold-time limit is compiled in with `define ARB_TIMEOUT_EN.
module mux_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic [2:0] owner
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Elaboration-time guard on the parameter ranges.
  if ((MAX_HOLD < 2) || (MAX_HOLD > 255) || ((64'd1 << CNT_W) <= 64'(MAX_HOLD))) begin : g_bad_cfg
    $error("mux_sel_arbiter: illegal MAX_HOLD/CNT_W combination");
  end

  // Returns {found, index} of the first request after 'last', wrapping past 7 to 0.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int i = 8; i >= 1; i--) begin
      idx = last + 3'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  state_t     state_r, state_s;
  logic [7:0] grant_r, grant_s;
  logic [2:0] sel_r,   sel_s;
  logic       busy_r,  busy_s;
  logic [2:0] last_r,  last_s;
  logic [3:0] pick_s;
  logic       exit_s;
  logic       timeout_s;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             at_limit_s;
  logic             other_s;

  // Forced hand-over only once the tenure has used its full budget and someone else waits.
  always_comb begin
    at_limit_s = (cnt_r == CNT_W'(MAX_HOLD - 1));
    other_s    = |(req & ~grant_r);
    timeout_s  = at_limit_s && other_s;
  end
`else
  assign timeout_s = 1'b0;
`endif

  assign pick_s = rr_pick(req, last_r);
  assign exit_s = (!req[sel_r]) || rel || timeout_s;

  // Next-state and next-output decode.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    sel_s   = sel_r;
    busy_s  = busy_r;
    last_s  = last_r;
`ifdef ARB_TIMEOUT_EN
    cnt_s   = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (pick_s[3]) begin
          state_s = GRANT;
          grant_s = 8'd1 << pick_s[2:0];
          sel_s   = pick_s[2:0];
          busy_s  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_s   = {CNT_W{1'b0}};
`endif
        end else begin
          grant_s = 8'd0;
          busy_s  = 1'b0;
        end
      end
      GRANT: begin
        if (exit_s) begin
          state_s = IDLE;
          grant_s = 8'd0;
          busy_s  = 1'b0;
          last_s  = sel_r;
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (!at_limit_s) begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_s = cnt_r;
          end
`endif
          grant_s = grant_r;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = 8'd0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops grant without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      grant_r <= 8'd0;
      sel_r   <= 3'd0;
      busy_r  <= 1'b0;
      last_r  <= 3'd7;
`ifdef ARB_TIMEOUT_EN
      cnt_r   <= {CNT_W{1'b0}};
`endif
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      sel_r   <= sel_s;
      busy_r  <= busy_s;
      last_r  <= last_s;
`ifdef ARB_TIMEOUT_EN
      cnt_r   <= cnt_s;
`endif
    end
  end

  assign grant = grant_r;
  assign sel   = sel_r;
  assign busy  = busy_r;
  assign owner = sel_r;

endmodule
